// File: rtl/modulus_counter_ctrl.sv
// rtl/modulus_counter_ctrl.sv - run controller for a runtime-configurable modulus counter
// Optional prescaler on the count enable is compiled in with MODULUS_CTRL_PRESCALE_EN.
module modulus_counter_ctrl #(
    parameter int MAX_MOD  = 53,
    parameter int CYC_W    = 8,
`ifdef MODULUS_CTRL_PRESCALE_EN
    parameter int PRESCALE = 4,
`endif
    localparam int MW = $clog2(MAX_MOD + 1),
    localparam int QW = $clog2(MAX_MOD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [MW-1:0]    cfg_mod,
    input  logic [CYC_W-1:0] cfg_cycles,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic             enable_n,
    output logic [QW-1:0]    Q,
    output logic             wrap,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [QW-1:0]      q_q, q_d;
    logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d, cyc_inc;
    logic [MW-1:0]      mod_q, mod_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic               enable_n_q, enable_n_d;
    logic               busy_q, busy_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               cfg_fire;
    logic               tick;
    logic               tick_d;

`ifdef MODULUS_CTRL_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre_q, pre_d;

    assign tick   = (pre_q == PW'(PRESCALE - 1));
    assign tick_d = (pre_d == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Prescaler restarts on start/stop and freezes while paused.
    always_comb begin
        pre_d = pre_q;
        if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
            pre_d = '0;
        end else if ((state_q == S_RUN || state_q == S_PAUSE) && stop) begin
            pre_d = '0;
        end else if (state_q == S_RUN && !pause) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
    end
`else
    assign tick   = 1'b1;
    assign tick_d = 1'b1;
`endif

    assign cfg_fire = cfg_valid && cfg_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            q_q         <= '0;
            cyc_cnt_q   <= '0;
            mod_q       <= MW'(MAX_MOD);
            cycles_q    <= '0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            enable_n_q  <= 1'b1;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            cyc_cnt_q   <= cyc_cnt_d;
            mod_q       <= mod_d;
            cycles_q    <= cycles_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            enable_n_q  <= enable_n_d;
            busy_q      <= busy_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        cyc_cnt_d = cyc_cnt_q;
        mod_d     = mod_q;
        cycles_d  = cycles_q;
        wrap_d    = 1'b0;
        done_d    = 1'b0;
        cyc_inc   = (&cyc_cnt_q) ? cyc_cnt_q : cyc_cnt_q + CYC_W'(1);

        // Out-of-range moduli fall back to the largest supported one.
        if (cfg_fire) begin
            if (cfg_mod == '0 || cfg_mod > MW'(MAX_MOD)) begin
                mod_d = MW'(MAX_MOD);
            end else begin
                mod_d = cfg_mod;
            end
            cycles_d = cfg_cycles;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    q_d       = '0;
                    cyc_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    q_d     = '0;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    if (MW'(q_q) == mod_q - MW'(1)) begin
                        q_d       = '0;
                        wrap_d    = 1'b1;
                        cyc_cnt_d = cyc_inc;
                        if (cycles_q != '0 && cyc_inc == cycles_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        q_d = q_q + QW'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    q_d     = '0;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        enable_n_d  = !(state_d == S_RUN && tick_d);
        busy_d      = (state_d == S_RUN) || (state_d == S_PAUSE);
        cfg_ready_d = !busy_d;
    end

    assign state     = state_q;
    assign Q         = q_q;
    assign wrap      = wrap_q;
    assign done      = done_q;
    assign enable_n  = enable_n_q;
    assign busy      = busy_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_modulus_counter_ctrl.sv
// tb/tb_modulus_counter_ctrl.sv - scoreboard bench for modulus_counter_ctrl
module tb_modulus_counter_ctrl;

    localparam int MAX_MOD = 53;
    localparam int CYC_W   = 8;
    localparam int MW      = 6;
    localparam int QW      = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_valid = 1'b0;
    logic [MW-1:0]    cfg_mod = '0;
    logic [CYC_W-1:0] cfg_cycles = '0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             stop = 1'b0;
    logic             cfg_ready, enable_n, wrap, done, busy;
    logic [QW-1:0]    Q;
    logic [1:0]       state;

    modulus_counter_ctrl #(.MAX_MOD(MAX_MOD), .CYC_W(CYC_W)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mod(cfg_mod), .cfg_cycles(cfg_cycles), .start(start), .pause(pause),
        .stop(stop), .enable_n(enable_n), .Q(Q), .wrap(wrap), .done(done),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    st;
        logic [QW-1:0] q;
        logic          en_n;
        logic          wr;
        logic          dn;
        logic          bsy;
        logic          rdy;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_wraps = 0;
    int   seen_wraps = 0;

    // Reference: phase codes 0 idle, 1 run, 2 pause, 3 done; counter kept as plain ints.
    int m_ph = 0, m_mod = MAX_MOD, m_cyc = 0, m_pos = 0, m_wraps = 0;
    bit m_wr = 0, m_dn = 0;

    task automatic model_step();
        obs_t e;
        if (reset) begin
            m_ph = 0; m_mod = MAX_MOD; m_cyc = 0; m_pos = 0; m_wraps = 0;
            m_wr = 0; m_dn = 0;
        end else begin
            m_wr = 0; m_dn = 0;
            if (cfg_valid && (m_ph == 0 || m_ph == 3)) begin
                m_mod = (cfg_mod == 0 || int'(cfg_mod) > MAX_MOD) ? MAX_MOD : int'(cfg_mod);
                m_cyc = int'(cfg_cycles);
            end
            if (m_ph == 0 || m_ph == 3) begin
                if (start) begin
                    m_ph = 1; m_pos = 0; m_wraps = 0;
                end
            end else if (stop) begin
                m_ph = 0; m_pos = 0;
            end else if (m_ph == 2) begin
                if (!pause) m_ph = 1;
            end else if (pause) begin
                m_ph = 2;
            end else begin
                m_pos = (m_pos + 1) % m_mod;
                if (m_pos == 0) begin
                    m_wr = 1;
                    exp_wraps++;
                    if (m_wraps < 255) m_wraps++;
                    if (m_cyc != 0 && m_wraps == m_cyc) begin
                        m_ph = 3; m_dn = 1;
                    end
                end
            end
        end
        e.st   = 2'(m_ph);
        e.q    = QW'(m_pos);
        e.en_n = (m_ph != 1);
        e.wr   = m_wr;
        e.dn   = m_dn;
        e.bsy  = (m_ph == 1 || m_ph == 2);
        e.rdy  = !(m_ph == 1 || m_ph == 2);
        sb.push_back(e);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            model_step();
        end
    endtask

    always @(negedge clk) begin : monitor
        obs_t e, a;
        if (wrap === 1'b1) seen_wraps++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            a = {state, Q, enable_n, wrap, done, busy, cfg_ready};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_check t=%0t got st=%0d q=%0d en_n=%b wrap=%b done=%b busy=%b rdy=%b want st=%0d q=%0d en_n=%b wrap=%b done=%b busy=%b rdy=%b",
                         $time, a.st, a.q, a.en_n, a.wr, a.dn, a.bsy, a.rdy,
                         e.st, e.q, e.en_n, e.wr, e.dn, e.bsy, e.rdy);
            end
        end
    end

    task automatic cfg_start(input int md, input int cy);
        cfg_valid = 1'b1; cfg_mod = MW'(md); cfg_cycles = CYC_W'(cy); start = 1'b1;
        step(1);
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    initial begin
        // Reset held two cycles
        reset = 1'b1;
        step(2);
        reset = 1'b0;

        // Finite run: mod 5, two wraps then done
        cfg_start(5, 2);
        step(12);

        // Clamp 60 -> 53, free running; config offered mid-run must be ignored
        cfg_start(60, 0);
        cfg_valid = 1'b1; cfg_mod = 6'd7; cfg_cycles = 8'd1;
        step(170);
        cfg_valid = 1'b0;
        stop = 1'b1; step(1); stop = 1'b0;
        cfg_start(0, 0);
        step(110);
        stop = 1'b1; step(1); stop = 1'b0;

        // Pause at Q=6 for four cycles
        cfg_start(10, 0);
        step(6);
        pause = 1'b1; step(4);
        pause = 1'b0; step(3);
        stop = 1'b1; step(1); stop = 1'b0;

        // Stop beats pause, then restart from 0
        cfg_start(10, 0);
        step(3);
        stop = 1'b1; pause = 1'b1; step(1);
        stop = 1'b0; pause = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(4);
        stop = 1'b1; step(1); stop = 1'b0;

        // Reset on the wrap cycle; default modulus must come back
        cfg_start(8, 1);
        step(7);
        reset = 1'b1; step(1); reset = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(60);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 499) == 0);
            start      = ($urandom_range(0, 7) == 0);
            pause      = ($urandom_range(0, 9) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            cfg_valid  = ($urandom_range(0, 4) == 0);
            cfg_mod    = ($urandom_range(0, 3) == 0) ? MW'($urandom_range(0, 63))
                                                     : MW'($urandom_range(1, 6));
            cfg_cycles = ($urandom_range(0, 3) == 0) ? '0 : CYC_W'($urandom_range(1, 4));
            step(1);
        end
        reset = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; cfg_valid = 1'b0;

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        checks++;
        if (seen_wraps != exp_wraps) begin
            errors++;
            $display("FAIL wrap_total got=%0d want=%0d", seen_wraps, exp_wraps);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
